// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side access port of the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, done, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter and sequencer for the data memory
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     r0,
    dmem_arbiter_if.slave     r1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_last_winner;
    logic                r_win;
    logic                r_we;
    logic                r_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_any_req;
    logic                w_pick;
    logic                w_sel_we;
    logic [31:0]         w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_err;
    logic                w_gnt;
    logic                w_done;
    logic [DATA_W-1:0]   w_cap_data;

    assign w_any_req = r0.req | r1.req;

    // On a tie the requester that did not win last time goes first.
    assign w_pick      = r1.req & (~r0.req | ~r_last_winner);
    assign w_sel_we    = w_pick ? r1.we    : r0.we;
    assign w_sel_addr  = w_pick ? r1.addr  : r0.addr;
    assign w_sel_wdata = w_pick ? r1.wdata : r0.wdata;
    assign w_sel_err   = (|w_sel_addr[1:0]) | (|w_sel_addr[31:ADDR_W+2]);

    assign w_cap_data  = (~r_we & ~r_err) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_gnt  = 1'b0;
        w_done = 1'b0;
        mem_we = 1'b0;
        mem_re = 1'b0;
        busy   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_gnt  = 1'b1;
                mem_we = r_we & ~r_err;
                mem_re = ~r_we & ~r_err;
                w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_winner <= 1'b1;
            r_win         <= 1'b0;
            r_we          <= 1'b0;
            r_err         <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_win         <= w_pick;
                r_last_winner <= w_pick;
                r_we          <= w_sel_we;
                r_err         <= w_sel_err;
                r_mem_addr    <= w_sel_addr[ADDR_W+1:2];
                r_mem_wdata   <= w_sel_wdata;
            end
            // Memory returns load data one edge after the strobe, i.e. during CAPTURE.
            if (r_state == S_CAPTURE) begin
                if (r_win) begin
                    r_rdata1 <= w_cap_data;
                end else begin
                    r_rdata0 <= w_cap_data;
                end
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign r0.gnt   = w_gnt & ~r_win;
    assign r1.gnt   = w_gnt & r_win;
    assign r0.done  = w_done & ~r_win;
    assign r1.done  = w_done & r_win;
    assign r0.err   = w_done & ~r_win & r_err;
    assign r1.err   = w_done & r_win & r_err;
    assign r0.rdata = r_rdata0;
    assign r1.rdata = r_rdata1;

endmodule
